// File: rtl/hash_writeback_if.sv
// Write-transaction handshake between the digest writeback stage and the burst master.
// The writeback stage is the master; the burst master side uses the slave modport.
interface hash_writeback_if #(
   parameter int DATA_WIDTH = 128
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic [31:0]           write_addr_index;
   logic                  init_write_txn;
   logic                  write_active;
   logic                  write_done;

   modport master (
      output wr_data,
      output write_addr_index,
      output init_write_txn,
      input  write_active,
      input  write_done
   );

   modport slave (
      input  wr_data,
      input  write_addr_index,
      input  init_write_txn,
      output write_active,
      output write_done
   );
endinterface

// File: rtl/hash_writeback.sv
// Captures the Keccak digest and writes it out as DATA_WIDTH beats, one burst-master
// write transaction per beat, with a per-wait timeout and done/busy/error status.
module hash_writeback #(
   parameter int          DATA_WIDTH     = 128,
   parameter int          HASH_WIDTH     = 512,
   parameter int          BEATS          = HASH_WIDTH / DATA_WIDTH,
   parameter logic [31:0] BASE_INDEX     = 32'd0,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [HASH_WIDTH-1:0] hash_in,
   input  logic                  hash_valid,
   hash_writeback_if.master      bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           debug
);

   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SLOTS = 1 << IDX_W;
   localparam int CNT_W = (IDX_W > 4) ? IDX_W : 4;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      ARMED       = 4'd1,
      ISSUE       = 4'd2,
      WAIT_ACTIVE = 4'd3,
      WAIT_DONE   = 4'd4,
      DONE        = 4'd5
   } state_t;

   state_t                state, state_n;
   logic [HASH_WIDTH-1:0] hash_reg, hash_n;
   logic [CNT_W-1:0]      beat_cnt, beat_n;
   logic [31:0]           addr_idx, idx_n;
   logic                  init_txn, init_n;
   logic                  done_r, done_n;
   logic                  error_r, error_n;
   logic [TMR_W-1:0]      timer, timer_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         hash_reg <= '0;
         beat_cnt <= '0;
         addr_idx <= BASE_INDEX;
         init_txn <= 1'b0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         timer    <= '0;
      end else begin
         state    <= state_n;
         hash_reg <= hash_n;
         beat_cnt <= beat_n;
         addr_idx <= idx_n;
         init_txn <= init_n;
         done_r   <= done_n;
         error_r  <= error_n;
         timer    <= timer_n;
      end
   end

   // A write_done seen while still waiting for write_active completes the beat
   // directly, and any completion outranks a timeout landing in the same cycle.
   always_comb begin
      state_n = state;
      hash_n  = hash_reg;
      beat_n  = beat_cnt;
      idx_n   = addr_idx;
      init_n  = 1'b0;
      done_n  = done_r;
      error_n = error_r;
      timer_n = timer;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = ARMED;
               done_n  = 1'b0;
               error_n = 1'b0;
               beat_n  = '0;
               idx_n   = BASE_INDEX;
            end
         end
         ARMED: begin
            if (hash_valid) begin
               hash_n  = hash_in;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            init_n  = 1'b1;
            timer_n = '0;
            state_n = WAIT_ACTIVE;
         end
         WAIT_ACTIVE, WAIT_DONE: begin
            timer_n = timer + TMR_W'(1);
            if (bus.write_done) begin
               if (beat_cnt == LAST_BEAT) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  beat_n  = beat_cnt + CNT_W'(1);
                  idx_n   = addr_idx + 32'd1;
                  state_n = ISSUE;
               end
            end else if (state == WAIT_ACTIVE && bus.write_active) begin
               state_n = WAIT_DONE;
               timer_n = '0;
            end else if (timer == TMR_LAST) begin
               error_n = 1'b1;
               done_n  = 1'b1;
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Most-significant digest slice goes out first; unused slots only pad the mux.
   logic [DATA_WIDTH-1:0] beat_words [SLOTS];
   for (genvar g = 0; g < SLOTS; g++) begin : g_beat
      if (g < BEATS) begin : g_used
         assign beat_words[g] = hash_reg[HASH_WIDTH-1-DATA_WIDTH*g -: DATA_WIDTH];
      end else begin : g_pad
         assign beat_words[g] = '0;
      end
   end

   assign bus.wr_data          = beat_words[beat_cnt[IDX_W-1:0]];
   assign bus.write_addr_index = addr_idx;
   assign bus.init_write_txn   = init_txn;

   assign busy  = (state == ARMED) || (state == ISSUE) ||
                  (state == WAIT_ACTIVE) || (state == WAIT_DONE);
   assign done  = done_r;
   assign error = error_r;
   assign debug = {19'b0, error_r, beat_cnt[3:0], 4'b0, state};

endmodule

// File: tb/tb_hash_writeback.sv
// Directed bench for hash_writeback: nominal, slow, simultaneous-handshake, timeout,
// mid-transfer reset and re-arm scenarios against hand-computed expectations.
module tb_hash_writeback;

   localparam int DW = 128;
   localparam int HW = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, hash_valid, busy, done, error;
   logic [HW-1:0] hash_in;
   logic [31:0]   debug;
   logic          start2, hash_valid2, busy2, done2, error2;
   logic [HW-1:0] hash_in2;
   logic [31:0]   debug2;

   hash_writeback_if #(.DATA_WIDTH(DW)) bus ();
   hash_writeback_if #(.DATA_WIDTH(DW)) bus2 ();

   hash_writeback dut (
      .clk(clk), .reset(reset), .start(start), .hash_in(hash_in),
      .hash_valid(hash_valid), .bus(bus), .busy(busy), .done(done),
      .error(error), .debug(debug)
   );

   hash_writeback #(.TIMEOUT_CYCLES(16)) dut_to (
      .clk(clk), .reset(reset), .start(start2), .hash_in(hash_in2),
      .hash_valid(hash_valid2), .bus(bus2), .busy(busy2), .done(done2),
      .error(error2), .debug(debug2)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int act_dly = 0;
   int done_dly = 0;
   bit simul = 1'b0;
   int init_cnt = 0;
   int unstable_cnt = 0;
   logic [31:0]   log_idx [64];
   logic [DW-1:0] log_data [64];
   logic [DW-1:0] cur_data = '0;

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_beats(input string tag, input int base,
                              input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      logic [DW-1:0] w [4];
      w = '{w0, w1, w2, w3};
      check_output({tag, " init pulses"}, DW'(init_cnt - base), DW'(4));
      for (int k = 0; k < 4; k++) begin
         check_output($sformatf("%s beat%0d index", tag, k), DW'(log_idx[(base + k) % 64]), DW'(k));
         check_output($sformatf("%s beat%0d data", tag, k), log_data[(base + k) % 64], w[k]);
      end
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (done !== 1'b1 && n < limit) begin
         wait_cycles(1);
         n++;
      end
      check_output({tag, " done within budget"}, DW'(done), DW'(1));
   endtask

   task automatic wait_beat_state(input string tag, input logic [3:0] bc, input logic [3:0] st, input int limit);
      int n = 0;
      while (!(debug[11:8] === bc && debug[3:0] === st) && n < limit) begin
         wait_cycles(1);
         n++;
      end
      check_output({tag, " reached beat/state"}, DW'(debug[11:0]), DW'({bc, 4'b0, st}));
   endtask

   task automatic apply_stimulus(input logic [HW-1:0] dig);
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      hash_in = dig;
      hash_valid = 1'b1;
      wait_cycles(1);
      hash_valid = 1'b0;
   endtask

   // Burst-master model: answers each init_write_txn with configurable delays.
   initial begin : master
      bus.write_active = 1'b0;
      bus.write_done   = 1'b0;
      forever begin
         wait_cycles(1);
         if (bus.init_write_txn === 1'b1) begin
            wait_cycles(act_dly);
            if (simul) begin
               bus.write_active = 1'b1;
               bus.write_done   = 1'b1;
               wait_cycles(1);
               bus.write_active = 1'b0;
               bus.write_done   = 1'b0;
            end else begin
               bus.write_active = 1'b1;
               wait_cycles(1);
               bus.write_active = 1'b0;
               wait_cycles(done_dly);
               bus.write_done = 1'b1;
               wait_cycles(1);
               bus.write_done = 1'b0;
            end
         end
      end
   end

   // Logs each issued beat and counts wr_data changes inside a beat's wait states.
   initial begin : monitor
      forever begin
         wait_cycles(1);
         if (bus.init_write_txn === 1'b1) begin
            log_idx[init_cnt % 64]  = bus.write_addr_index;
            log_data[init_cnt % 64] = bus.wr_data;
            cur_data = bus.wr_data;
            init_cnt++;
         end else if ((debug[3:0] == 4'd3 || debug[3:0] == 4'd4) && bus.wr_data !== cur_data) begin
            unstable_cnt++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int base;
      int ubase;
      reset = 1'b1;
      start = 1'b0;
      hash_valid = 1'b0;
      hash_in = '0;
      start2 = 1'b0;
      hash_valid2 = 1'b0;
      hash_in2 = '0;
      bus2.write_active = 1'b0;
      bus2.write_done = 1'b0;
      wait_cycles(3);
      reset = 1'b0;

      check_output("reset debug", DW'(debug), DW'(0));
      check_output("reset init", DW'(bus.init_write_txn), DW'(0));
      check_output("reset index", DW'(bus.write_addr_index), DW'(0));
      check_output("reset done", DW'(done), DW'(0));
      check_output("reset error", DW'(error), DW'(0));
      check_output("reset busy", DW'(busy), DW'(0));
      check_output("reset wr_data", bus.wr_data, '0);

      hash_in = {4{128'h5555_5555_5555_5555_5555_5555_5555_5555}};
      hash_valid = 1'b1;
      wait_cycles(2);
      check_output("idle ignores hash_valid", DW'(debug), DW'(0));
      hash_valid = 1'b0;

      // Nominal: ideal master, digest changes after capture must not leak out.
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      check_output("nominal armed state", DW'(debug[3:0]), DW'(1));
      check_output("nominal armed busy", DW'(busy), DW'(1));
      base = init_cnt;
      hash_in = {{32{4'hA}}, {32{4'hB}}, {32{4'hC}}, {32{4'hD}}};
      hash_valid = 1'b1;
      wait_cycles(1);
      check_output("nominal issue after 1 cycle", DW'(debug[3:0]), DW'(2));
      hash_in = {4{128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000}};
      wait_cycles(11);
      check_output("nominal done not early", DW'(done), DW'(0));
      wait_cycles(1);
      check_output("nominal done at 13", DW'(done), DW'(1));
      check_output("nominal error", DW'(error), DW'(0));
      check_output("nominal busy", DW'(busy), DW'(0));
      check_output("nominal final index", DW'(bus.write_addr_index), DW'(3));
      check_output("nominal debug", DW'(debug), DW'(32'h0000_0305));
      check_beats("nominal", base, {32{4'hA}}, {32{4'hB}}, {32{4'hC}}, {32{4'hD}});
      hash_valid = 1'b0;

      // Slow master: re-armed from DONE.
      act_dly = 5;
      done_dly = 20;
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      check_output("slow rearm clears done", DW'(done), DW'(0));
      base = init_cnt;
      ubase = unstable_cnt;
      hash_in = {128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                 128'h8899_AABB_CCDD_EEFF_1357_9BDF_2468_ACE0,
                 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0,
                 128'h0F0F_0F0F_F0F0_F0F0_3C3C_3C3C_C3C3_C3C3};
      hash_valid = 1'b1;
      wait_cycles(1);
      hash_valid = 1'b0;
      wait_done("slow", 400);
      check_output("slow error", DW'(error), DW'(0));
      check_output("slow wr_data stable", DW'(unstable_cnt - ubase), DW'(0));
      check_beats("slow", base,
                  128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                  128'h8899_AABB_CCDD_EEFF_1357_9BDF_2468_ACE0,
                  128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0,
                  128'h0F0F_0F0F_F0F0_F0F0_3C3C_3C3C_C3C3_C3C3);

      // Simultaneous write_active/write_done, plus a stray start mid-transfer.
      act_dly = 0;
      done_dly = 0;
      simul = 1'b1;
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      base = init_cnt;
      hash_in = {{32{4'h1}}, {32{4'h2}}, {32{4'h3}}, {32{4'h4}}};
      hash_valid = 1'b1;
      wait_cycles(1);
      hash_valid = 1'b0;
      wait_cycles(2);
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      wait_cycles(4);
      check_output("simul done not early", DW'(done), DW'(0));
      wait_cycles(1);
      check_output("simul done at 9", DW'(done), DW'(1));
      check_output("simul error", DW'(error), DW'(0));
      check_output("simul final index", DW'(bus.write_addr_index), DW'(3));
      check_beats("simul", base, {32{4'h1}}, {32{4'h2}}, {32{4'h3}}, {32{4'h4}});
      simul = 1'b0;

      // Timeout on the 16-cycle instance: write_active never arrives.
      start2 = 1'b1;
      wait_cycles(1);
      start2 = 1'b0;
      hash_in2 = {{32{4'h9}}, {32{4'h8}}, {32{4'h7}}, {32{4'h6}}};
      hash_valid2 = 1'b1;
      wait_cycles(1);
      hash_valid2 = 1'b0;
      wait_cycles(16);
      check_output("timeout done not early", DW'(done2), DW'(0));
      wait_cycles(1);
      check_output("timeout done", DW'(done2), DW'(1));
      check_output("timeout error", DW'(error2), DW'(1));
      check_output("timeout index", DW'(bus2.write_addr_index), DW'(0));
      check_output("timeout debug12", DW'(debug2[12]), DW'(1));
      check_output("timeout debug", DW'(debug2), DW'(32'h0000_1005));
      check_output("timeout busy", DW'(busy2), DW'(0));

      // Reset while beat 2 sits in WAIT_DONE.
      done_dly = 20;
      apply_stimulus({{32{4'hE}}, {32{4'h7}}, {32{4'h3}}, {32{4'h1}}});
      wait_beat_state("reset mid", 4'd2, 4'd4, 200);
      reset = 1'b1;
      wait_cycles(1);
      check_output("midreset debug", DW'(debug), DW'(0));
      check_output("midreset init", DW'(bus.init_write_txn), DW'(0));
      check_output("midreset index", DW'(bus.write_addr_index), DW'(0));
      check_output("midreset done", DW'(done), DW'(0));
      check_output("midreset error", DW'(error), DW'(0));
      check_output("midreset busy", DW'(busy), DW'(0));
      check_output("midreset wr_data", bus.wr_data, '0);
      reset = 1'b0;
      base = init_cnt;
      wait_cycles(30);
      check_output("midreset stays idle", DW'(debug), DW'(0));
      check_output("midreset no init", DW'(init_cnt - base), DW'(0));
      done_dly = 0;

      // Fresh transfer from IDLE after the reset.
      base = init_cnt;
      apply_stimulus({{32{4'h2}}, {32{4'h4}}, {32{4'h6}}, {32{4'h8}}});
      wait_done("fresh", 50);
      check_output("fresh error", DW'(error), DW'(0));
      check_beats("fresh", base, {32{4'h2}}, {32{4'h4}}, {32{4'h6}}, {32{4'h8}});

      // Re-arm from DONE with a new digest.
      base = init_cnt;
      apply_stimulus({128'h1111_2222_3333_4444_5555_6666_7777_8888,
                      128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000,
                      128'h0000_0001_0000_0002_0000_0003_0000_0004,
                      128'hF00D_F00D_BEEF_BEEF_F00D_F00D_BEEF_BEEF});
      wait_done("rearm", 50);
      check_output("rearm final index", DW'(bus.write_addr_index), DW'(3));
      check_beats("rearm", base,
                  128'h1111_2222_3333_4444_5555_6666_7777_8888,
                  128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000,
                  128'h0000_0001_0000_0002_0000_0003_0000_0004,
                  128'hF00D_F00D_BEEF_BEEF_F00D_F00D_BEEF_BEEF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
